rect_scheduler: RTL and testbench
=================================

RECT_SCHEDULER -- requirements
Module: rect_scheduler

Interface
REQ-001 SHALL have parameter NUM_RECTS, default 8, number of rectangle slots (power of 2, 2..16).
REQ-002 SHALL have parameter COLOR_W, default 8, color width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_valid  in  1  descriptor write request.
REQ-006 SHALL have port wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-007 SHALL have port wr_slot  in  log2(NUM_RECTS)  target slot; slot 0 is highest priority.
REQ-008 SHALL have ports wr_x, wr_y, wr_w, wr_h  in  10 each  top-left corner and size in pixels.
REQ-009 SHALL have port wr_color  in  COLOR_W  fill color.
REQ-010 SHALL have port wr_enable  in  1  slot enable.
REQ-011 SHALL have port frame_start  in  1  one-cycle pulse at vertical blank start.
REQ-012 SHALL have port line_start  in  1  one-cycle pulse at hblank start; next_y is valid with it.
REQ-013 SHALL have port next_y  in  10  line about to be drawn.
REQ-014 SHALL have ports x_pixel  in  10  and pix_valid  in  1  current active pixel.
REQ-015 SHALL have ports hit  out  1  and color  out  COLOR_W  registered pixel result.
REQ-016 SHALL have ports scan_busy  out  1  and scan_overrun  out  1 (sticky).

Function
REQ-017 Accepted writes SHALL update the shadow bank only; the active bank is unchanged.
REQ-018 On frame_start the shadow bank SHALL copy to the active bank in one cycle; wr_ready SHALL be 0 in that cycle and 1 otherwise.
REQ-019 Scan FSM states SHALL be IDLE and SCAN; IDLE+line_start -> SCAN, latch next_y, idx=0.
REQ-020 In SCAN, one slot per cycle SHALL be tested through the shared hit unit: mask[idx] = enable && w!=0 && h!=0 && y_pos <= y < y_pos+h.
REQ-021 After idx=NUM_RECTS-1 the FSM SHALL load row_mask from mask and return to IDLE; row_mask updates NUM_RECTS+1 cycles after line_start.
REQ-022 scan_busy SHALL be 1 exactly while in SCAN.
REQ-023 line_start during SCAN SHALL restart the scan with the new next_y and set scan_overrun.
REQ-024 frame_start during SCAN SHALL abort to IDLE and clear row_mask to 0; frame_start in IDLE SHALL also clear row_mask.
REQ-025 All end-coordinate sums SHALL be 11-bit, without wrap; rectangles past 1023 are clipped.
REQ-026 When pix_valid=1, hit/color SHALL register one cycle later the lowest-index slot with row_mask set and x_pos <= x_pixel < x_pos+w.
REQ-027 When pix_valid=0 or there is no match, hit and color SHALL both be 0 on the next cycle.

Reset
REQ-028 Reset SHALL clear both banks, row_mask, hit, color, scan_busy, and scan_overrun; the FSM SHALL go to IDLE and wr_ready SHALL be 1.
REQ-029 Reset mid-scan SHALL discard the partial mask.

Configuration
REQ-030 With RECT_TRANSPARENT_EN defined, a matching slot whose color is 0 SHALL be skipped and the next-priority match SHALL be used.
REQ-031 Without RECT_TRANSPARENT_EN, color 0 SHALL be an opaque match that produces hit=1 and color=0.

Structure
REQ-032 Package rect_pkg SHALL hold COORD_W=10, the default NUM_RECTS, and the descriptor typedef {x,y,w,h,color,enable}.
REQ-033 Sub-module rect_hit_unit SHALL be the single shared 11-bit range tester, instantiated once for the row scan.

Verification
REQ-034 Test: write slot 2 {x=100,y=50,w=20,h=10,color=0x1C,en=1}; no frame_start; line_start y=55 -> hit=0 at x=105.
REQ-035 Test: same write, then frame_start, then line_start y=55 -> scan_busy for 8 cycles; pix x=105 -> hit=1, color=0x1C; x=120 -> hit=0; y=60 line -> hit=0.
REQ-036 Test: slot 0 {0,0,640,480,0x03} and slot 1 {10,10,5,5,0xE0}; x=12,y=12 -> color=0x03; with RECT_TRANSPARENT_EN and slot 0 color=0 -> color=0xE0.
REQ-037 Test: line_start, then a second line_start 3 cycles later -> scan_overrun=1; row_mask reflects the second y after 9 more cycles.
REQ-038 Test: slot {x=1020,w=10,...} -> hit at x=1023; w=0 slot -> never hit.
REQ-039 Test: assert reset mid-SCAN -> all outputs 0 and wr_ready=1 while reset is high.

Source files
------------

// File: rtl/rect_pkg.sv
// rect_pkg: shared coordinate width, default slot count, descriptor type and range helper.
package rect_pkg;
  localparam int COORD_W = 10;
  localparam int NUM_RECTS_DEF = 8;
  localparam int COLOR_MAX_W = 16;
  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [COORD_W-1:0]     w;
    logic [COORD_W-1:0]     h;
    logic [COLOR_MAX_W-1:0] color;
    logic                   enable;
  } rect_desc_t;
  // End is computed in 11 bits so spans past 1023 clip instead of wrapping.
  function automatic logic in_range(logic [COORD_W-1:0] pos, logic [COORD_W-1:0] len, logic [COORD_W-1:0] val);
    return ({1'b0, val} >= {1'b0, pos}) && ({1'b0, val} < ({1'b0, pos} + {1'b0, len}));
  endfunction
endpackage

// File: rtl/rect_hit_unit.sv
// rect_hit_unit: 11-bit range tester shared by the row scan, one slot per cycle.
module rect_hit_unit import rect_pkg::*; (
  input  logic               en_i,
  input  logic [COORD_W-1:0] pos_i,
  input  logic [COORD_W-1:0] len_i,
  input  logic [COORD_W-1:0] val_i,
  output logic               hit_o
);
  assign hit_o = en_i && (len_i != '0) && in_range(pos_i, len_i, val_i);
endmodule

// File: rtl/rect_scheduler.sv
// rect_scheduler: double-buffered rectangle overlay with per-line slot scan and per-pixel priority pick.
// Define RECT_TRANSPARENT_EN to make color-0 slots transparent instead of opaque.
module rect_scheduler import rect_pkg::*; #(
  parameter int NUM_RECTS = NUM_RECTS_DEF,
  parameter int COLOR_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(NUM_RECTS)-1:0] wr_slot,
  input  logic [COORD_W-1:0]           wr_x,
  input  logic [COORD_W-1:0]           wr_y,
  input  logic [COORD_W-1:0]           wr_w,
  input  logic [COORD_W-1:0]           wr_h,
  input  logic [COLOR_W-1:0]           wr_color,
  input  logic                         wr_enable,
  input  logic                         frame_start,
  input  logic                         line_start,
  input  logic [COORD_W-1:0]           next_y,
  input  logic [COORD_W-1:0]           x_pixel,
  input  logic                         pix_valid,
  output logic                         hit,
  output logic [COLOR_W-1:0]           color,
  output logic                         scan_busy,
  output logic                         scan_overrun
);
  localparam int IW = $clog2(NUM_RECTS);
  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;
`ifdef RECT_TRANSPARENT_EN
  localparam logic SKIP_ZERO = 1'b1;
`else
  localparam logic SKIP_ZERO = 1'b0;
`endif
  rect_desc_t shadow_q [NUM_RECTS];
  rect_desc_t active_q [NUM_RECTS];
  logic state_q, state_d, overrun_q, overrun_d, hit_q, row_hit, sel_hit;
  logic [IW-1:0] idx_q, idx_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [NUM_RECTS-1:0] mask_q, mask_d, row_mask_q, row_mask_d;
  logic [COLOR_W-1:0] color_q, sel_color;
  assign wr_ready = reset || !frame_start;
  assign scan_busy = state_q == SCAN;
  assign scan_overrun = overrun_q;
  assign hit = hit_q;
  assign color = color_q;
  rect_hit_unit u_hit (
    .en_i  (active_q[idx_q].enable && active_q[idx_q].w != '0),
    .pos_i (active_q[idx_q].y),
    .len_i (active_q[idx_q].h),
    .val_i (y_q),
    .hit_o (row_hit)
  );
  // A new line_start restarts the scan; frame_start has the final word and empties the row.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q + 1'b1;
    y_d = y_q;
    mask_d = mask_q;
    row_mask_d = row_mask_q;
    overrun_d = overrun_q;
    if (state_q == SCAN) begin
      mask_d[idx_q] = row_hit;
      if (idx_q == IW'(NUM_RECTS - 1)) begin
        state_d = IDLE;
        row_mask_d = mask_d;
      end
    end
    if (line_start) begin
      state_d = SCAN;
      idx_d = '0;
      y_d = next_y;
      mask_d = '0;
      overrun_d = overrun_q || (state_q == SCAN);
    end
    if (frame_start) begin
      state_d = IDLE;
      row_mask_d = '0;
    end
  end
  // Walk from lowest priority upward so slot 0 overwrites everything else.
  always_comb begin
    sel_hit = 1'b0;
    sel_color = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (row_mask_q[i] && in_range(active_q[i].x, active_q[i].w, x_pixel) &&
          !(SKIP_ZERO && active_q[i].color[COLOR_W-1:0] == '0)) begin
        sel_hit = 1'b1;
        sel_color = active_q[i].color[COLOR_W-1:0];
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      state_q <= IDLE;
      idx_q <= '0;
      y_q <= '0;
      mask_q <= '0;
      row_mask_q <= '0;
      overrun_q <= 1'b0;
      hit_q <= 1'b0;
      color_q <= '0;
    end else begin
      if (wr_valid && wr_ready)
        shadow_q[wr_slot] <= '{x: wr_x, y: wr_y, w: wr_w, h: wr_h,
                               color: COLOR_MAX_W'(wr_color), enable: wr_enable};
      if (frame_start) active_q <= shadow_q;
      state_q <= state_d;
      idx_q <= idx_d;
      y_q <= y_d;
      mask_q <= mask_d;
      row_mask_q <= row_mask_d;
      overrun_q <= overrun_d;
      hit_q <= pix_valid && sel_hit;
      color_q <= pix_valid ? sel_color : '0;
    end
  end
endmodule

// File: tb/tb_rect_scheduler.sv
// tb_rect_scheduler: directed bench with a pixel-result scoreboard for rect_scheduler.
module tb_rect_scheduler;
  localparam int CW = 8;
  logic clk = 0, reset = 1, wr_valid = 0, wr_enable = 0, frame_start = 0, line_start = 0, pix_valid = 0;
  logic wr_ready, hit, scan_busy, scan_overrun;
  logic [2:0] wr_slot = '0;
  logic [9:0] wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0, next_y = '0, x_pixel = '0;
  logic [CW-1:0] wr_color = '0, color;
  int n_tests = 0, n_fail = 0;
  logic [CW:0] exp_q[$];

  always #5 clk = ~clk;

  rect_scheduler #(.NUM_RECTS(8), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
    .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .wr_color(wr_color), .wr_enable(wr_enable),
    .frame_start(frame_start), .line_start(line_start), .next_y(next_y), .x_pixel(x_pixel),
    .pix_valid(pix_valid), .hit(hit), .color(color), .scan_busy(scan_busy), .scan_overrun(scan_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] s, input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                    input logic [9:0] h, input logic [CW-1:0] c, input logic en);
    wr_valid = 1; wr_slot = s; wr_x = x; wr_y = y; wr_w = w; wr_h = h; wr_color = c; wr_enable = en;
    tick;
    wr_valid = 0;
  endtask

  task automatic frame;
    frame_start = 1;
    #1;
    chk("wr_ready_in_frame", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    frame_start = 0;
  endtask

  task automatic line(input logic [9:0] y, input string tag);
    int n;
    line_start = 1; next_y = y;
    tick;
    line_start = 0;
    n = 0;
    while (scan_busy && n < 20) begin
      n++;
      tick;
    end
    chk(tag, 32'(n), 32'd8);
  endtask

  task automatic pix(input logic [9:0] x, input logic v, input logic h, input logic [CW-1:0] c, input string tag);
    pix_valid = v; x_pixel = x;
    exp_q.push_back({h, c});
    tick;
    pix_valid = 0;
    chk(tag, 32'({hit, color}), 32'(exp_q.pop_front()));
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_overrun", 32'(scan_overrun), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 0;
    tick;
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);

    wr(3'd2, 10'd100, 10'd50, 10'd20, 10'd10, 8'h1C, 1'b1);
    line(10'd55, "busy_no_frame");
    pix(10'd105, 1, 0, 8'h00, "shadow_only");

    frame;
    line(10'd55, "busy_y55");
    pix(10'd105, 1, 1, 8'h1C, "hit_x105");
    pix(10'd119, 1, 1, 8'h1C, "hit_x119");
    pix(10'd120, 1, 0, 8'h00, "miss_x120");
    pix(10'd99, 1, 0, 8'h00, "miss_x99");
    pix(10'd105, 0, 0, 8'h00, "pix_invalid");
    line(10'd60, "busy_y60");
    pix(10'd105, 1, 0, 8'h00, "miss_y60");
    line(10'd59, "busy_y59");
    pix(10'd105, 1, 1, 8'h1C, "hit_y59");
    chk("no_overrun_yet", 32'(scan_overrun), 32'd0);

    wr(3'd0, 10'd0, 10'd0, 10'd640, 10'd480, 8'h03, 1'b1);
    wr(3'd1, 10'd10, 10'd10, 10'd5, 10'd5, 8'hE0, 1'b1);
    frame;
    line(10'd12, "busy_y12");
    pix(10'd12, 1, 1, 8'h03, "prio_slot0");
    pix(10'd700, 1, 0, 8'h00, "miss_x700");
    wr(3'd0, 10'd0, 10'd0, 10'd640, 10'd480, 8'h00, 1'b1);
    frame;
    line(10'd12, "busy_y12_b");
`ifdef RECT_TRANSPARENT_EN
    pix(10'd12, 1, 1, 8'hE0, "transparent_slot0");
`else
    pix(10'd12, 1, 1, 8'h00, "opaque_color0");
`endif

    line_start = 1; next_y = 10'd12;
    tick;
    line_start = 0;
    tick;
    tick;
    chk("busy_before_restart", 32'(scan_busy), 32'd1);
    line(10'd600, "busy_restart");
    chk("overrun_set", 32'(scan_overrun), 32'd1);
    pix(10'd12, 1, 0, 8'h00, "mask_second_y");

    wr(3'd3, 10'd1020, 10'd700, 10'd10, 10'd5, 8'h55, 1'b1);
    wr(3'd4, 10'd0, 10'd700, 10'd0, 10'd5, 8'h77, 1'b1);
    wr(3'd5, 10'd0, 10'd700, 10'd50, 10'd0, 8'h66, 1'b1);
    wr(3'd6, 10'd200, 10'd700, 10'd50, 10'd5, 8'h44, 1'b0);
    frame;
    line(10'd702, "busy_y702");
    pix(10'd1023, 1, 1, 8'h55, "clip_x1023");
    pix(10'd1019, 1, 0, 8'h00, "miss_x1019");
    pix(10'd0, 1, 0, 8'h00, "w0_h0_never");
    pix(10'd210, 1, 0, 8'h00, "disabled_slot");
    line(10'd705, "busy_y705");
    pix(10'd1023, 1, 0, 8'h00, "miss_y705");
    line(10'd702, "busy_y702_b");
    frame;
    pix(10'd1023, 1, 0, 8'h00, "frame_clears_mask");
    chk("overrun_sticky", 32'(scan_overrun), 32'd1);

    line(10'd702, "busy_y702_c");
    line_start = 1; next_y = 10'd702;
    tick;
    line_start = 0; pix_valid = 1; x_pixel = 10'd1023;
    tick;
    tick;
    chk("pre_reset_hit", 32'(hit), 32'd1);
    reset = 1;
    #1;
    chk("midscan_rst_hit", 32'(hit), 32'd0);
    chk("midscan_rst_color", 32'(color), 32'd0);
    chk("midscan_rst_busy", 32'(scan_busy), 32'd0);
    chk("midscan_rst_overrun", 32'(scan_overrun), 32'd0);
    chk("midscan_rst_wr_ready", 32'(wr_ready), 32'd1);
    pix_valid = 0;
    tick;
    reset = 0;
    tick;
    frame;
    line(10'd702, "busy_after_reset");
    pix(10'd1023, 1, 0, 8'h00, "banks_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
